// File: rtl/alu_mdu.sv
// Iterative multiply/divide unit with architectural HI/LO registers and a start/busy/done handshake.
// Define MDU_DIV_EN to build the restoring divider; without it DIV/DIVU complete as NOPs with done.
module alu_mdu #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_zero
);

   localparam int unsigned CntW = $clog2(WIDTH);

   localparam logic [2:0] OpMult  = 3'b000;
   localparam logic [2:0] OpMultu = 3'b001;
   localparam logic [2:0] OpDiv   = 3'b010;
   localparam logic [2:0] OpDivu  = 3'b011;
   localparam logic [2:0] OpMthi  = 3'b100;
   localparam logic [2:0] OpMtlo  = 3'b101;

   typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

   state_e             state_q, state_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [2*WIDTH-1:0] work_q, work_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic               neg_q, neg_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               dz_q, dz_d;

   // Odd op codes are the unsigned variants.
   logic             sign_a, sign_b;
   logic [WIDTH-1:0] mag_a, mag_b;
   logic             accept;

   assign sign_a = ~op[0] & a[WIDTH-1];
   assign sign_b = ~op[0] & b[WIDTH-1];
   assign mag_a  = sign_a ? -a : a;
   assign mag_b  = sign_b ? -b : b;
   assign accept = start & ((state_q == StIdle) || (state_q == StDone)) & (op[2:1] != 2'b11);

   // Shift-add step: multiplier sits in the low half and is consumed LSB first.
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [2*WIDTH-1:0] prod_fix;

   assign mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
   assign mul_next = work_q[0] ? {mul_sum, work_q[WIDTH-1:1]} : {1'b0, work_q[2*WIDTH-1:1]};
   assign prod_fix = neg_q ? -work_q : work_q;

`ifdef MDU_DIV_EN
   logic is_div_q, is_div_d;
   logic sa_q, sa_d;

   // Restoring step: remainder in the high half, dividend shifts out / quotient shifts in low.
   logic [WIDTH:0]     div_sh;
   logic [WIDTH:0]     div_diff;
   logic               div_ge;
   logic [WIDTH-1:0]   div_rem;
   logic [2*WIDTH-1:0] div_next;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   assign div_sh   = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
   assign div_diff = div_sh - {1'b0, opnd_q};
   assign div_ge   = ~div_diff[WIDTH];
   assign div_rem  = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
   assign div_next = {div_rem, work_q[WIDTH-2:0], div_ge};
   assign quo_fix  = neg_q ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
   assign rem_fix  = sa_q ? -work_q[2*WIDTH-1:WIDTH] : work_q[2*WIDTH-1:WIDTH];
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      work_d   = work_q;
      opnd_d   = opnd_q;
      neg_d    = neg_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      hi_d     = hi_q;
      lo_d     = lo_q;
      dz_d     = dz_q;
`ifdef MDU_DIV_EN
      is_div_d = is_div_q;
      sa_d     = sa_q;
`endif
      case (state_q)
         StIdle, StDone: begin
            state_d = StIdle;
            busy_d  = 1'b0;
            if (accept) begin
               dz_d  = 1'b0;
               neg_d = sign_a ^ sign_b;
               case (op)
                  OpMult, OpMultu: begin
                     state_d  = StCalc;
                     busy_d   = 1'b1;
                     cnt_d    = CntW'(WIDTH - 1);
                     opnd_d   = mag_a;
                     work_d   = {{WIDTH{1'b0}}, mag_b};
`ifdef MDU_DIV_EN
                     is_div_d = 1'b0;
`endif
                  end
                  OpDiv, OpDivu: begin
`ifdef MDU_DIV_EN
                     if (b == '0) begin
                        hi_d    = a;
                        lo_d    = '1;
                        dz_d    = 1'b1;
                        state_d = StDone;
                        done_d  = 1'b1;
                     end else begin
                        state_d  = StCalc;
                        busy_d   = 1'b1;
                        cnt_d    = CntW'(WIDTH - 1);
                        opnd_d   = mag_b;
                        work_d   = {{WIDTH{1'b0}}, mag_a};
                        is_div_d = 1'b1;
                        sa_d     = sign_a;
                     end
`else
                     state_d = StDone;
                     done_d  = 1'b1;
`endif
                  end
                  OpMthi: begin
                     hi_d    = a;
                     state_d = StDone;
                     done_d  = 1'b1;
                  end
                  OpMtlo: begin
                     lo_d    = a;
                     state_d = StDone;
                     done_d  = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
         StCalc: begin
            busy_d = 1'b1;
`ifdef MDU_DIV_EN
            work_d = is_div_q ? div_next : mul_next;
`else
            work_d = mul_next;
`endif
            if (cnt_q == '0) begin
               state_d = StFix;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         StFix: begin
`ifdef MDU_DIV_EN
            if (is_div_q) begin
               hi_d = rem_fix;
               lo_d = quo_fix;
            end else begin
               hi_d = prod_fix[2*WIDTH-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end
`else
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
`endif
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         work_q   <= '0;
         opnd_q   <= '0;
         neg_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         dz_q     <= 1'b0;
`ifdef MDU_DIV_EN
         is_div_q <= 1'b0;
         sa_q     <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         work_q   <= work_d;
         opnd_q   <= opnd_d;
         neg_q    <= neg_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         dz_q     <= dz_d;
`ifdef MDU_DIV_EN
         is_div_q <= is_div_d;
         sa_q     <= sa_d;
`endif
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign hi       = hi_q;
   assign lo       = lo_q;
   assign div_zero = dz_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Directed self-checking bench for alu_mdu; divider checks follow the MDU_DIV_EN build setting.
module tb_alu_mdu;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rstn;
   logic         start;
   logic [2:0]   op;
   logic [W-1:0] a, b;
   logic         busy, done, div_zero;
   logic [W-1:0] hi, lo;

   int total = 0;
   int bad   = 0;
   int lat, bcnt, dcnt;

   alu_mdu #(.WIDTH(W)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .hi       (hi),
      .lo       (lo),
      .div_zero (div_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Issue one request, scramble operands afterwards, return done latency and busy cycles.
   task automatic run(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                      output int l, output int bc);
      @(negedge clk);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      @(negedge clk);
      start = 1'b0;
      op    = 3'b110;
      a     = $urandom;
      b     = $urandom;
      l     = 1;
      bc    = 0;
      while (done !== 1'b1 && l < 100) begin
         if (busy === 1'b1) bc++;
         @(negedge clk);
         l++;
      end
   endtask

   initial begin
      rstn  = 1'b1;
      start = 1'b0;
      op    = 3'b110;
      a     = '0;
      b     = '0;
      #2 rstn = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_hi", {32'd0, hi}, 64'd0);
      chk("rst_lo", {32'd0, lo}, 64'd0);
      chk("rst_dz", {63'd0, div_zero}, 64'd0);
      rstn = 1'b1;

      run(3'b000, 32'hFFFF_FFFD, 32'd7, lat, bcnt);
      chk("mult_lat", 64'(lat), 64'd34);
      chk("mult_busy", 64'(bcnt), 64'd33);
      chk("mult_hi", {32'd0, hi}, 64'hFFFF_FFFF);
      chk("mult_lo", {32'd0, lo}, 64'hFFFF_FFEB);
      @(negedge clk);
      chk("mult_done_pulse", {63'd0, done}, 64'd0);

      run(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt);
      chk("multu_hi", {32'd0, hi}, 64'hFFFF_FFFE);
      chk("multu_lo", {32'd0, lo}, 64'h0000_0001);

      run(3'b000, 32'hFFFF_FFFB, 32'hFFFF_FFFA, lat, bcnt);
      chk("mult_negneg", {hi, lo}, 64'd30);
      run(3'b000, 32'h8000_0000, 32'h8000_0000, lat, bcnt);
      chk("mult_minmin", {hi, lo}, 64'h4000_0000_0000_0000);
      run(3'b001, 32'h8000_0000, 32'd2, lat, bcnt);
      chk("multu_min2", {hi, lo}, 64'h0000_0001_0000_0000);
      run(3'b000, 32'h8000_0000, 32'd2, lat, bcnt);
      chk("mult_min2", {hi, lo}, 64'hFFFF_FFFF_0000_0000);

      // MTHI followed by MTLO accepted in the DONE cycle.
      @(negedge clk);
      start = 1'b1;
      op    = 3'b100;
      a     = 32'h1234;
      @(negedge clk);
      chk("mthi_done", {63'd0, done}, 64'd1);
      chk("mthi_busy", {63'd0, busy}, 64'd0);
      chk("mthi_hi", {32'd0, hi}, 64'h1234);
      op = 3'b101;
      a  = 32'h5678;
      @(negedge clk);
      start = 1'b0;
      op    = 3'b110;
      chk("mtlo_done", {63'd0, done}, 64'd1);
      chk("mtlo_hilo", {hi, lo}, 64'h0000_1234_0000_5678);
      @(negedge clk);
      chk("mt_done_fall", {63'd0, done}, 64'd0);

`ifdef MDU_DIV_EN
      run(3'b010, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
      chk("div_lat", 64'(lat), 64'd34);
      chk("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      run(3'b011, 32'd100, 32'd7, lat, bcnt);
      chk("divu", {hi, lo}, 64'h0000_0002_0000_000E);
      run(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
      chk("div_min_m1", {hi, lo}, 64'h0000_0000_8000_0000);
      run(3'b010, 32'd5, 32'd0, lat, bcnt);
      chk("dz_lat", 64'(lat), 64'd1);
      chk("dz_busy", 64'(bcnt + int'(busy)), 64'd0);
      chk("dz_flag", {63'd0, div_zero}, 64'd1);
      chk("dz_hilo", {hi, lo}, 64'h0000_0005_FFFF_FFFF);
      run(3'b001, 32'd2, 32'd3, lat, bcnt);
      chk("dz_cleared", {63'd0, div_zero}, 64'd0);
      chk("multu_small", {hi, lo}, 64'd6);
`else
      run(3'b100, 32'hA5A5_A5A5, 32'd0, lat, bcnt);
      run(3'b101, 32'hA5A5_A5A5, 32'd0, lat, bcnt);
      run(3'b010, 32'd9, 32'd3, lat, bcnt);
      chk("nodiv_lat", 64'(lat), 64'd1);
      chk("nodiv_busy", 64'(bcnt + int'(busy)), 64'd0);
      chk("nodiv_hilo", {hi, lo}, 64'hA5A5_A5A5_A5A5_A5A5);
      chk("nodiv_dz", {63'd0, div_zero}, 64'd0);
`endif

      // Start while busy is dropped; reset mid-op aborts without done.
      run(3'b100, 32'h1111, 32'd0, lat, bcnt);
      run(3'b101, 32'h2222, 32'd0, lat, bcnt);
      @(negedge clk);
      start = 1'b1;
      op    = 3'b000;
      a     = 32'd3;
      b     = 32'd4;
      @(negedge clk);
      start = 1'b0;
      op    = 3'b110;
      repeat (3) @(negedge clk);
      start = 1'b1;
      op    = 3'b100;
      a     = 32'hDEAD;
      @(negedge clk);
      start = 1'b0;
      op    = 3'b110;
      chk("ign_busy", {63'd0, busy}, 64'd1);
      chk("ign_hilo", {hi, lo}, 64'h0000_1111_0000_2222);
      repeat (4) @(negedge clk);
      rstn = 1'b0;
      #1;
      chk("abort_busy", {63'd0, busy}, 64'd0);
      chk("abort_hilo", {hi, lo}, 64'd0);
      @(negedge clk);
      rstn = 1'b1;
      dcnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1) dcnt++;
      end
      chk("abort_no_done", 64'(dcnt), 64'd0);
      chk("abort_idle_busy", {63'd0, busy}, 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers, sitting beside the single-cycle ALU in the EX stage. It executes MULT/MULTU/DIV/DIVU iteratively (one bit per cycle) and MTHI/MTLO in one cycle. It exposes a start/busy/done handshake so the pipeline control can stall while an operation is in flight.

## Interface
- WIDTH, 32, operand/result width in bits; must be ≥ 2.
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only when busy=0.
- op  in  3  operation select: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 are NOP.
- a  in  WIDTH  operand A (multiplicand/dividend/MT source); sampled at the accept edge only.
- b  in  WIDTH  operand B (multiplier/divisor); sampled at the accept edge only.
- busy  out  1  operation in flight; new requests are ignored while high.
- done  out  1  one-cycle completion pulse.
- hi  out  WIDTH  HI register: product upper half / remainder.
- lo  out  WIDTH  LO register: product lower half / quotient.
- div_zero  out  1  last completed op was a divide with b=0; valid while done=1, held until the next accept.

## Operation
- States: IDLE, CALC, FIX, DONE.
- Accept: start=1 in IDLE or DONE. Operands, op and signs are latched, and div_zero is cleared.
- MULT/DIV/MULTU/DIVU with b≠0 (or any MULT): go to CALC with iteration counter = WIDTH-1.
- MTHI/MTLO: write hi (or lo) from a at the accept edge, then go to DONE.
- NOP: ignored; the state is unchanged.
- Divide with b=0: go directly to DONE with hi=a, lo=all-ones, div_zero=1. No iteration.
- CALC, multiply: shift-add on |a|,|b| (raw for MULTU) into a 2·WIDTH working register. One bit per cycle; leave to FIX when the counter reaches 0.
- CALC, divide: restoring division on |a|,|b| (raw for DIVU). One quotient bit per cycle; leave to FIX when the counter reaches 0.
- FIX (1 cycle), sign correction for signed ops:
  - Product is negated (2·WIDTH two's complement) if sign(a)≠sign(b).
  - Quotient is negated if sign(a)≠sign(b).
  - Remainder takes the sign of a.
- FIX then commits hi/lo and moves to DONE.
- DONE (1 cycle): done=1, busy=0, then return to IDLE, unless a new accept occurs in the same cycle.
- hi/lo are separate from the working registers. They change only at commit or MT writes and never show intermediate values.
- Signed MIN/−1 is not trapped. The result is lo=MIN, hi=0.
- Arithmetic: unsigned magnitudes are WIDTH bits, and |MIN| is treated as 2^(WIDTH-1) unsigned.

## Timing
- Reset values: busy=0, done=0, hi=0, lo=0, div_zero=0, state IDLE, counter 0.
- Assertion of rstn is immediate. Deassertion is synchronous to clk in the surrounding logic.
- Reset mid-operation aborts the op and clears hi/lo; no done is produced.
- Accept edge = E0.
- MULT/DIV: busy=1 from after E0 through FIX (WIDTH+1 cycles). hi/lo and done are visible after edge E0+WIDTH+1, and done falls after E0+WIDTH+2. For WIDTH=32, done is the 34th cycle after the request cycle.
- MT*, divide-by-zero: busy stays 0. done is high in the cycle after E0, and hi/lo update at E0.
- start while busy=1 is dropped. There is no queueing, and operands may change freely.
- start in the DONE cycle is accepted back-to-back. done still pulses for the completing op.

## Configuration
- MDU_DIV_EN defined: the divider datapath is compiled in, and DIV/DIVU behave as above.
- MDU_DIV_EN undefined: no divider logic is built. DIV/DIVU complete like NOP-with-done: done pulses in the cycle after E0, hi/lo are unchanged, div_zero=0, and busy is never asserted.
- Multiply and MT ops are unaffected by the macro.

## Test plan
- MULT a=0xFFFFFFFD (−3), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB; done in the 34th cycle after the request; busy high for 33 cycles.
- MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. MTHI a=0x1234, then MTLO a=0x5678 back-to-back → hi=0x1234, lo=0x5678, done pulses once per op.
- DIV a=−7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 → lo=14, hi=2. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- DIV a=5, b=0 → hi=5, lo=0xFFFFFFFF, div_zero=1 with done one cycle after accept, busy never high.
- MULT in flight, start with op=MTHI at cycle 5 → ignored, hi unchanged by it. Then rstn low at cycle 10 → busy=0, hi=lo=0, no done.
- Build without MDU_DIV_EN: preload hi=lo=0xA5A5A5A5 via MTHI/MTLO, then DIV a=9, b=3 → done after 1 cycle, hi=lo=0xA5A5A5A5, div_zero=0.
